// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round scheduler and its arbiter.
package aes_pkg;

  localparam int unsigned AES_NROUNDS = 10;
  localparam int unsigned AES_BLK_W   = 128;
  localparam int unsigned AES_RCNT_W  = 4;
  localparam int unsigned AES_NCH     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } aes_state_e;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the channel
// that was not granted last.
module aes_rr_arb2
  import aes_pkg::*;
(
  input  logic [AES_NCH-1:0] req_valid_i,
  input  logic               last_id_i,
  output logic [AES_NCH-1:0] gnt_c_o,
  output logic               gnt_id_c_o
);

  always_comb begin
    gnt_id_c_o = 1'b0;
    gnt_c_o    = '0;
    case (req_valid_i)
      2'b01:   gnt_id_c_o = 1'b0;
      2'b10:   gnt_id_c_o = 1'b1;
      2'b11:   gnt_id_c_o = ~last_id_i;
      default: gnt_id_c_o = 1'b0;
    endcase
    if (|req_valid_i) begin
      gnt_c_o = gnt_id_c_o ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/aes_round_sched.sv
// Shares one single-round AES core between two block requesters.
// Optional per-channel completion counters: define AES_ROUND_SCHED_STATS_EN.
module aes_round_sched
  import aes_pkg::*;
#(
  parameter int unsigned BLK_W = AES_BLK_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [AES_NCH-1:0]    req_valid,
  output logic [AES_NCH-1:0]    req_ready,
  input  logic [BLK_W-1:0]      req_data0,
  input  logic [BLK_W-1:0]      req_data1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLK_W-1:0]      out_data,
  output logic                  out_id,
  output logic                  busy,
  output logic                  core_enable,
  output logic [AES_RCNT_W-1:0] core_round,
  output logic [BLK_W-1:0]      core_i_text,
  input  logic [BLK_W-1:0]      core_o_text,
  input  logic [BLK_W-1:0]      core_rkey,
  output logic [CNT_W-1:0]      stat_cnt0,
  output logic [CNT_W-1:0]      stat_cnt1
);

  aes_state_e            state_q, state_d;
  logic [AES_RCNT_W-1:0] rcnt_q, rcnt_d;
  logic                  last_id_q, last_id_d;
  logic                  cur_id_q, cur_id_d;
  logic [BLK_W-1:0]      result_q, result_d;

  logic [AES_NCH-1:0]    gnt_c;
  logic                  gnt_id_c;
  logic [AES_NCH-1:0]    req_ready_c;
  logic                  core_enable_c;
  logic [AES_RCNT_W-1:0] core_round_c;
  logic [BLK_W-1:0]      core_i_text_c;
  logic                  out_hs_c;

  aes_rr_arb2 u_arb (
    .req_valid_i (req_valid),
    .last_id_i   (last_id_q),
    .gnt_c_o     (gnt_c),
    .gnt_id_c_o  (gnt_id_c)
  );

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= IDLE;
      rcnt_q    <= '0;
      last_id_q <= 1'b1;
      cur_id_q  <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      last_id_q <= last_id_d;
      cur_id_q  <= cur_id_d;
      result_q  <= result_d;
    end
  end

  // Next state and core drive; round 0 (AddRoundKey + first round) issues in the accept cycle.
  always_comb begin
    state_d       = state_q;
    rcnt_d        = rcnt_q;
    last_id_d     = last_id_q;
    cur_id_d      = cur_id_q;
    result_d      = result_q;
    req_ready_c   = '0;
    core_enable_c = 1'b0;
    core_round_c  = '0;
    core_i_text_c = '0;
    case (state_q)
      IDLE: begin
        req_ready_c = gnt_c;
        if (|gnt_c) begin
          core_enable_c = 1'b1;
          core_i_text_c = (gnt_id_c ? req_data1 : req_data0) ^ core_rkey;
          rcnt_d        = AES_RCNT_W'(1);
          cur_id_d      = gnt_id_c;
          last_id_d     = gnt_id_c;
          state_d       = RUN;
        end
      end
      RUN: begin
        core_enable_c = 1'b1;
        core_round_c  = rcnt_q;
        core_i_text_c = core_o_text;
        rcnt_d        = rcnt_q + AES_RCNT_W'(1);
        if (rcnt_q == AES_RCNT_W'(AES_NROUNDS - 1)) begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        result_d = core_o_text;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) begin
          rcnt_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Combinational outputs are held quiet while reset is asserted.
  assign req_ready   = resetn ? req_ready_c : '0;
  assign core_enable = resetn & core_enable_c;
  assign core_round  = resetn ? core_round_c : '0;
  assign core_i_text = resetn ? core_i_text_c : '0;

  assign out_valid = (state_q == DONE);
  assign out_data  = result_q;
  assign out_id    = cur_id_q;
  assign busy      = (state_q != IDLE);
  assign out_hs_c  = out_valid & out_ready;

`ifdef AES_ROUND_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Saturating completion counters, bumped on each output handshake.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (out_hs_c && !cur_id_q && !(&cnt0_q)) cnt0_d = cnt0_q + CNT_W'(1);
    if (out_hs_c &&  cur_id_q && !(&cnt1_q)) cnt1_d = cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign stat_cnt0 = cnt0_q;
  assign stat_cnt1 = cnt1_q;
`else
  logic unused_hs_c;
  assign unused_hs_c = out_hs_c;
  assign stat_cnt0   = '0;
  assign stat_cnt1   = '0;
`endif

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: behavioural single-round AES core plus a
// transaction-level model of the scheduler checked every cycle.
module tb_aes_round_sched;

`ifdef AES_ROUND_SCHED_STATS_EN
  localparam int CNT_W    = 2;
  localparam int EXP_CNT1 = 3;
`else
  localparam int CNT_W    = 16;
  localparam int EXP_CNT1 = 0;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clock = 1'b0;
  logic         resetn;
  logic [1:0]   req_valid, req_ready;
  logic [127:0] req_data0, req_data1;
  logic         out_valid, out_ready, out_id, busy, core_enable;
  logic [127:0] out_data, core_i_text, core_rkey;
  logic [127:0] core_o_text = '0;
  logic [3:0]   core_round;
  logic [CNT_W-1:0] stat_cnt0, stat_cnt1;

  always #5 clock = ~clock;

  aes_round_sched #(.BLK_W(128), .CNT_W(CNT_W)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data0(req_data0), .req_data1(req_data1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .busy(busy),
    .core_enable(core_enable), .core_round(core_round),
    .core_i_text(core_i_text), .core_o_text(core_o_text),
    .core_rkey(core_rkey),
    .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- AES reference arithmetic ----------------
  logic [7:0]   sbox [256];
  logic [127:0] rk [11];
  logic [127:0] key;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic key_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One AES round r (0..9): SubBytes, ShiftRows, MixColumns (not last), AddRoundKey r+1.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input int r);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = s[127 - 8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) b[rr + 4*c] = sbox[a[rr + 4*((c + rr) % 4)]];
    if (r < 9) begin
      for (int c = 0; c < 4; c++) begin
        a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
        b[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        b[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        b[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        b[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = b[i];
    return o ^ rk[r+1];
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk[0];
    for (int r = 0; r < 10; r++) s = aes_round(s, r);
    return s;
  endfunction

  // Single-round core: registered o_text, round key for the current round.
  assign core_rkey = (core_round <= 4'd10) ? rk[core_round] : '0;
  always @(posedge clock)
    if (core_enable) core_o_text <= aes_round(core_i_text, int'(core_round));

  // ---------------- scheduler model and per-cycle compare ----------------
  int           cyc = 0;
  int           m_phase = -1;
  logic         m_last = 1'b1;
  logic         m_id = 1'b0;
  logic         m_just_rst = 1'b0;
  logic [127:0] m_ct, m_last_out, pt;
  logic         m_last_id;
  int           m_cnt0 = 0, m_cnt1 = 0, m_done = 0;
  int           m_acc_cyc = 0, m_val_cyc = 0;
  logic         g_id;
  logic [1:0]   exp_rdy;
  logic [1:0]   acc = 2'b00;
  logic         gq [$];

  always @(negedge clock) begin
    cyc++;
    acc = 2'b00;
    if (!resetn) begin
      chk("rst_req_ready", 128'(req_ready), 128'(0));
      chk("rst_core_enable", 128'(core_enable), 128'(0));
      chk("rst_core_round", 128'(core_round), 128'(0));
      chk("rst_core_i_text", core_i_text, 128'(0));
      m_phase = -1; m_last = 1'b1; m_cnt0 = 0; m_cnt1 = 0; m_just_rst = 1'b1;
    end else begin
      if (m_just_rst) begin
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_out_id", 128'(out_id), 128'(0));
        m_just_rst = 1'b0;
      end
      chk("stat_cnt0", 128'(stat_cnt0), 128'(m_cnt0));
      chk("stat_cnt1", 128'(stat_cnt1), 128'(m_cnt1));
      if (m_phase < 0) begin
        g_id    = (req_valid == 2'b11) ? ~m_last : req_valid[1];
        exp_rdy = (req_valid == 2'b00) ? 2'b00 : (g_id ? 2'b10 : 2'b01);
        chk("idle_req_ready", 128'(req_ready), 128'(exp_rdy));
        chk("idle_busy", 128'(busy), 128'(0));
        chk("idle_out_valid", 128'(out_valid), 128'(0));
        chk("idle_core_round", 128'(core_round), 128'(0));
        if (req_valid != 2'b00) begin
          pt = g_id ? req_data1 : req_data0;
          chk("acc_core_enable", 128'(core_enable), 128'(1));
          chk("acc_core_i_text", core_i_text, pt ^ key);
          m_id = g_id; m_last = g_id; m_ct = aes_encrypt(pt);
          m_phase = 1; m_acc_cyc = cyc; gq.push_back(g_id); acc[g_id] = 1'b1;
        end else begin
          chk("idle_core_enable", 128'(core_enable), 128'(0));
          chk("idle_core_i_text", core_i_text, 128'(0));
        end
      end else if (m_phase <= 9) begin
        chk("run_core_enable", 128'(core_enable), 128'(1));
        chk("run_core_round", 128'(core_round), 128'(m_phase));
        chk("run_core_i_text", core_i_text, core_o_text);
        chk("run_req_ready", 128'(req_ready), 128'(0));
        chk("run_busy", 128'(busy), 128'(1));
        chk("run_out_valid", 128'(out_valid), 128'(0));
        m_phase++;
      end else if (m_phase == 10) begin
        chk("capt_core_enable", 128'(core_enable), 128'(0));
        chk("capt_core_round", 128'(core_round), 128'(0));
        chk("capt_core_i_text", core_i_text, 128'(0));
        chk("capt_req_ready", 128'(req_ready), 128'(0));
        chk("capt_out_valid", 128'(out_valid), 128'(0));
        chk("capt_busy", 128'(busy), 128'(1));
        m_phase++;
      end else begin
        if (m_phase == 11) m_val_cyc = cyc;
        chk("done_out_valid", 128'(out_valid), 128'(1));
        chk("done_out_data", out_data, m_ct);
        chk("done_out_id", 128'(out_id), 128'(m_id));
        chk("done_req_ready", 128'(req_ready), 128'(0));
        chk("done_core_enable", 128'(core_enable), 128'(0));
        chk("done_busy", 128'(busy), 128'(1));
        if (out_ready) begin
          m_done++; m_last_out = out_data; m_last_id = out_id;
`ifdef AES_ROUND_SCHED_STATS_EN
          if (m_id) begin if (m_cnt1 < CNT_MAX) m_cnt1++; end
          else begin if (m_cnt0 < CNT_MAX) m_cnt0++; end
`endif
          m_phase = -1;
        end else begin
          m_phase++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset(input int n);
    @(posedge clock); #1;
    resetn = 1'b0; req_valid = 2'b00; out_ready = 1'b0;
    repeat (n) @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  task automatic run_cycles(input int n, input int pv, input int pr);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      for (int ch = 0; ch < 2; ch++) begin
        if (acc[ch] || !req_valid[ch]) begin
          req_valid[ch] = (int'($urandom_range(99)) < pv);
          if (ch == 0) req_data0 = rnd128(); else req_data1 = rnd128();
        end
      end
      out_ready = (int'($urandom_range(99)) < pr);
    end
  endtask

  task automatic send_one(input int ch, input logic [127:0] d);
    int t, d0;
    @(posedge clock); #1;
    if (ch == 0) req_data0 = d; else req_data1 = d;
    req_valid = (ch == 0) ? 2'b01 : 2'b10;
    out_ready = 1'b1;
    t = 0;
    do begin @(posedge clock); #1; t++; end while (!acc[ch] && t < 30);
    chk("send_accepted", 128'(acc[ch]), 128'(1));
    req_valid = 2'b00;
    d0 = m_done; t = 0;
    while (m_done == d0 && t < 30) begin @(posedge clock); #1; t++; end
    chk("send_completed", 128'(m_done - d0), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout expected finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [127:0] d;
    logic exp_seq [4];
    resetn = 1'b0; req_valid = 2'b00; out_ready = 1'b0;
    req_data0 = '0; req_data1 = '0;
    build_sbox();
    key = FIPS_KEY;
    key_expand(key);
    chk("model_sbox_00", 128'(sbox[0]), 128'(8'h63));
    chk("model_sbox_53", 128'(sbox[8'h53]), 128'(8'hed));
    chk("model_fips", aes_encrypt(FIPS_PT), FIPS_CT);
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;

    // FIPS-197 vector through the DUT, latency accept -> out_valid.
    send_one(0, FIPS_PT);
    chk("fips_out_data", m_last_out, FIPS_CT);
    chk("fips_out_id", 128'(m_last_id), 128'(0));
    chk("fips_latency", 128'(m_val_cyc - m_acc_cyc), 128'(11));

    // Both channels always valid from reset: grants alternate 0,1,0,1.
    do_reset(2);
    gq.delete();
    run_cycles(50, 100, 100);
    exp_seq[0] = 1'b0; exp_seq[1] = 1'b1; exp_seq[2] = 1'b0; exp_seq[3] = 1'b1;
    chk("alt_grant_count", 128'(gq.size() >= 4), 128'(1));
    for (int i = 0; i < 4; i++)
      if (gq.size() > i) chk($sformatf("alt_grant_%0d", i), 128'(gq[i]), 128'(exp_seq[i]));

    // Consumer stall in DONE for 20 cycles; new requests must wait.
    do_reset(2);
    @(posedge clock); #1;
    req_data1 = rnd128(); req_valid = 2'b10; out_ready = 1'b0;
    t = 0;
    do begin @(posedge clock); #1; if (acc[1]) req_valid = 2'b00; t++; end
    while (!out_valid && t < 30);
    chk("stall_reached_done", 128'(out_valid), 128'(1));
    req_data0 = rnd128(); req_data1 = rnd128(); req_valid = 2'b11;
    repeat (20) @(posedge clock);
    #1 chk("stall_still_valid", 128'(out_valid), 128'(1));
    out_ready = 1'b1;
    run_cycles(40, 100, 100);

    // Reset during round 5 discards the block; next block is clean.
    do_reset(2);
    @(posedge clock); #1;
    req_data0 = rnd128(); req_valid = 2'b01; out_ready = 1'b1;
    t = 0;
    do begin @(posedge clock); #1; if (acc[0]) req_valid = 2'b00; t++; end
    while (!(core_enable && core_round == 4'd4) && t < 30);
    chk("midrun_reached_round4", 128'(core_round), 128'(4));
    @(posedge clock); #1 resetn = 1'b0;
    @(posedge clock); #1 resetn = 1'b1;
    chk("post_rst_out_valid", 128'(out_valid), 128'(0));
    chk("post_rst_busy", 128'(busy), 128'(0));
    chk("post_rst_out_data", out_data, 128'(0));
    d = rnd128();
    send_one(1, d);
    chk("post_rst_ct", m_last_out, aes_encrypt(d));
    chk("post_rst_id", 128'(m_last_id), 128'(1));

    // Randomized traffic with random backpressure.
    do_reset(1);
    run_cycles(400, 50, 60);

    // Completion counters: five channel-1 blocks after reset.
    do_reset(2);
    for (int b = 0; b < 5; b++) send_one(1, rnd128());
    chk("stat_cnt1_final", 128'(stat_cnt1), 128'(EXP_CNT1));
    chk("stat_cnt0_final", 128'(stat_cnt0), 128'(0));

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
